// File: rtl/apb_master_bridge.sv
// Bridges the core's single-request data bus onto APB3 for up to four 4 KiB-page slaves.
// Optional ACCESS-phase watchdog is enabled by defining APB_TIMEOUT_EN.
module apb_master_bridge #(
  parameter int          NUM_SLAVES     = 4,
  parameter logic [19:0] BASE_PAGE      = 20'h1000_0,
  parameter int          TIMEOUT_CYCLES = 255
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     transfer,
  input  logic                     busWe,
  input  logic [31:0]              busAddr,
  input  logic [31:0]              busWData,
  input  logic [3:0]               Byte_Enable,
  output logic [31:0]              busRData,
  output logic                     busReady,
  output logic                     busErr,
  output logic [31:0]              PADDR,
  output logic [NUM_SLAVES-1:0]    PSEL,
  output logic                     PENABLE,
  output logic                     PWRITE,
  output logic [31:0]              PWDATA,
  output logic [3:0]               PSTRB,
  input  logic [32*NUM_SLAVES-1:0] PRDATA,
  input  logic [NUM_SLAVES-1:0]    PREADY,
  input  logic [NUM_SLAVES-1:0]    PSLVERR
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DONE} state_e;

  state_e                state_q, state_d;
  logic [NUM_SLAVES-1:0] psel_q, psel_d;
  logic                  penable_q, penable_d;
  logic                  pwrite_q, pwrite_d;
  logic [31:0]           paddr_q, paddr_d;
  logic [31:0]           pwdata_q, pwdata_d;
  logic [3:0]            pstrb_q, pstrb_d;
  logic [31:0]           rdata_q, rdata_d;
  logic                  ready_q, ready_d;
  logic                  err_q, err_d;
`ifdef APB_TIMEOUT_EN
  localparam logic [7:0] TIMEOUT_LIMIT = 8'(TIMEOUT_CYCLES);
  logic [7:0]            cnt_q, cnt_d;
`endif

  // Page offset from the base; pages below BASE_PAGE wrap to large values and decode as unmapped.
  logic [19:0]           page_off;
  logic [NUM_SLAVES-1:0] dec_onehot;
  logic                  pready_sel;
  logic                  pslverr_sel;
  logic [31:0]           prdata_sel;

  always_comb begin
    page_off = busAddr[31:12] - BASE_PAGE;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      dec_onehot[i] = (page_off == 20'(i));
    end
  end

  // PSEL is one-hot, so masking with it picks the selected slave's response.
  always_comb begin
    pready_sel  = |(PREADY & psel_q);
    pslverr_sel = |(PSLVERR & psel_q);
    prdata_sel  = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      prdata_sel = prdata_sel | (PRDATA[32*i +: 32] & {32{psel_q[i]}});
    end
  end

  always_comb begin
    // NOTE: every next-state value gets a default first so no path through the case infers a latch.
    state_d   = state_q;
    psel_d    = psel_q;
    penable_d = penable_q;
    pwrite_d  = pwrite_q;
    paddr_d   = paddr_q;
    pwdata_d  = pwdata_q;
    pstrb_d   = pstrb_q;
    rdata_d   = rdata_q;
    err_d     = err_q;
    ready_d   = 1'b0;
`ifdef APB_TIMEOUT_EN
    cnt_d     = cnt_q;
`endif

    unique case (state_q)
      IDLE: begin
        if (transfer) begin
          pwrite_d = busWe;
          paddr_d  = {20'h0, busAddr[11:0]};
          pwdata_d = busWData;
          pstrb_d  = busWe ? Byte_Enable : 4'b0000;
          if (|dec_onehot) begin
            psel_d  = dec_onehot;
            state_d = SETUP;
`ifdef APB_TIMEOUT_EN
            cnt_d   = '0;
`endif
          end else begin
            rdata_d = '0;
            err_d   = 1'b1;
            ready_d = 1'b1;
            state_d = DONE;
          end
        end
      end
      SETUP: begin
        penable_d = 1'b1;
        state_d   = ACCESS;
      end
      ACCESS: begin
        if (pready_sel) begin
          rdata_d   = pwrite_q ? 32'h0 : prdata_sel;
          err_d     = pslverr_sel;
          ready_d   = 1'b1;
          psel_d    = '0;
          penable_d = 1'b0;
          state_d   = DONE;
        end
`ifdef APB_TIMEOUT_EN
        else begin
          cnt_d = cnt_q + 8'd1;
          if (cnt_d == TIMEOUT_LIMIT) begin
            rdata_d   = 32'hDEAD_BEEF;
            err_d     = 1'b1;
            ready_d   = 1'b1;
            psel_d    = '0;
            penable_d = 1'b0;
            state_d   = DONE;
          end
        end
`endif
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: reset is synchronous, so it only acts on a rising edge; state uses <= so all registers see pre-edge values.
    if (!reset) begin
      state_q   <= IDLE;
      psel_q    <= '0;
      penable_q <= 1'b0;
      pwrite_q  <= 1'b0;
      paddr_q   <= '0;
      pwdata_q  <= '0;
      pstrb_q   <= '0;
      rdata_q   <= '0;
      ready_q   <= 1'b0;
      err_q     <= 1'b0;
`ifdef APB_TIMEOUT_EN
      cnt_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      psel_q    <= psel_d;
      penable_q <= penable_d;
      pwrite_q  <= pwrite_d;
      paddr_q   <= paddr_d;
      pwdata_q  <= pwdata_d;
      pstrb_q   <= pstrb_d;
      rdata_q   <= rdata_d;
      ready_q   <= ready_d;
      err_q     <= err_d;
`ifdef APB_TIMEOUT_EN
      cnt_q     <= cnt_d;
`endif
    end
  end

  assign PSEL     = psel_q;
  assign PENABLE  = penable_q;
  assign PWRITE   = pwrite_q;
  assign PADDR    = paddr_q;
  assign PWDATA   = pwdata_q;
  assign PSTRB    = pstrb_q;
  assign busRData = rdata_q;
  assign busReady = ready_q;
  assign busErr   = err_q;

endmodule

// File: tb/tb_apb_master_bridge.sv
// Self-checking bench for apb_master_bridge: a transaction-level timeline model predicts every
// cycle's outputs; a single compare process checks them, plus literal checks of the directed cases.
module tb_apb_master_bridge;

  localparam int          NS = 4;
  localparam logic [19:0] BP = 20'h1000_0;
  localparam int          TO = 4;

  logic            clk;
  logic            reset;
  logic            transfer;
  logic            busWe;
  logic [31:0]     busAddr;
  logic [31:0]     busWData;
  logic [3:0]      Byte_Enable;
  logic [31:0]     busRData;
  logic            busReady;
  logic            busErr;
  logic [31:0]     PADDR;
  logic [NS-1:0]   PSEL;
  logic            PENABLE;
  logic            PWRITE;
  logic [31:0]     PWDATA;
  logic [3:0]      PSTRB;
  logic [32*NS-1:0] PRDATA;
  logic [NS-1:0]   PREADY;
  logic [NS-1:0]   PSLVERR;

  apb_master_bridge #(
    .NUM_SLAVES(NS), .BASE_PAGE(BP), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .reset(reset), .transfer(transfer), .busWe(busWe), .busAddr(busAddr),
    .busWData(busWData), .Byte_Enable(Byte_Enable), .busRData(busRData), .busReady(busReady),
    .busErr(busErr), .PADDR(PADDR), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PWDATA(PWDATA), .PSTRB(PSTRB), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected outputs for one cycle; queue holds the predicted timeline of the current transfer.
  typedef struct {
    logic [NS-1:0] psel;
    logic          penable;
    logic          pwrite;
    logic [31:0]   paddr;
    logic [31:0]   pwdata;
    logic [3:0]    pstrb;
    logic          ready;
    logic [31:0]   rdata;
    logic          err;
  } exp_t;

  exp_t exp_q[$];
  exp_t cmp_e;
  bit   exp_reset = 1'b0;
  int   checks    = 0;
  int   failures  = 0;
  int   cyc       = 0;
  int   start_cyc = 0;

  // Observed values recorded for the literal checks.
  logic [NS-1:0] mon_psel;
  logic [31:0]   mon_paddr;
  logic [3:0]    mon_pstrb;
  logic [31:0]   mon_rdata;
  logic          mon_err;
  int            mon_rdy_cyc = -1;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (PSEL != '0 && !PENABLE) begin
      mon_psel  = PSEL;
      mon_paddr = PADDR;
      mon_pstrb = PSTRB;
    end
    if (busReady === 1'b1) begin
      mon_rdy_cyc = cyc;
      mon_rdata   = busRData;
      mon_err     = busErr;
    end
  end

  always @(negedge clk) begin
    bit ok;
    if (exp_reset) begin
      checks++;
      if ({PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB, busRData, busReady, busErr} !== '0) begin
        failures++;
        $display("FAIL reset_outputs cyc=%0d: got psel=%b pen=%b pw=%b paddr=%h pwdata=%h pstrb=%b rdata=%h rdy=%b err=%b expected all zero",
                 cyc, PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB, busRData, busReady, busErr);
      end
    end else if (exp_q.size() > 0) begin
      cmp_e = exp_q.pop_front();
      ok = (PSEL === cmp_e.psel) && (PENABLE === cmp_e.penable) && (busReady === cmp_e.ready);
      if (cmp_e.psel != '0)
        ok = ok && (PADDR === cmp_e.paddr) && (PWRITE === cmp_e.pwrite) && (PSTRB === cmp_e.pstrb)
                && (!cmp_e.pwrite || PWDATA === cmp_e.pwdata);
      if (cmp_e.ready)
        ok = ok && (busRData === cmp_e.rdata) && (busErr === cmp_e.err);
      checks++;
      if (!ok) begin
        failures++;
        $display("FAIL cycle_model cyc=%0d: got psel=%b pen=%b pw=%b paddr=%h pwdata=%h pstrb=%b rdy=%b rdata=%h err=%b expected psel=%b pen=%b pw=%b paddr=%h pwdata=%h pstrb=%b rdy=%b rdata=%h err=%b",
                 cyc, PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB, busReady, busRData, busErr,
                 cmp_e.psel, cmp_e.penable, cmp_e.pwrite, cmp_e.paddr, cmp_e.pwdata, cmp_e.pstrb,
                 cmp_e.ready, cmp_e.rdata, cmp_e.err);
      end
    end else begin
      checks++;
      if (PSEL !== '0 || PENABLE !== 1'b0 || busReady !== 1'b0) begin
        failures++;
        $display("FAIL idle_cycle cyc=%0d: got psel=%b pen=%b rdy=%b expected psel=0 pen=0 rdy=0",
                 cyc, PSEL, PENABLE, busReady);
      end
    end
  end

  task automatic rand_slaves();
    PRDATA  = {$urandom(), $urandom(), $urandom(), $urandom()};
    PREADY  = 4'($urandom());
    PSLVERR = 4'($urandom());
  endtask

  task automatic junk_bus();
    transfer    = 1'($urandom());
    busWe       = 1'($urandom());
    busAddr     = $urandom();
    busWData    = $urandom();
    Byte_Enable = 4'($urandom());
  endtask

  task automatic idle_cycle();
    transfer = 1'b0;
    rand_slaves();
    @(posedge clk); #1;
  endtask

  // Issues one transfer from an IDLE cycle and returns in the IDLE cycle after DONE.
  task automatic do_xfer(input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] be, input int waits, input logic [31:0] rd,
                         input bit serr);
    logic [19:0] off;
    int          s;
    int          acc;
    logic [31:0] res;
    bit          rerr;
    exp_t        e;
    off = addr[31:12] - BP;
    s   = int'(off);
    transfer = 1'b1; busWe = we; busAddr = addr; busWData = wdata; Byte_Enable = be;
    rand_slaves();
    mon_rdy_cyc = -1;
    @(posedge clk); #1;
    start_cyc = cyc;
    e = '{default: '0};
    if (off >= 20'(NS)) begin
      e.ready = 1'b1; e.rdata = 32'h0; e.err = 1'b1;
      exp_q.push_back(e);
    end else begin
      acc  = waits + 1;
      res  = we ? 32'h0 : rd;
      rerr = serr;
`ifdef APB_TIMEOUT_EN
      if (waits >= TO) begin
        acc = TO; res = 32'hDEAD_BEEF; rerr = 1'b1;
      end
`endif
      e.psel[s] = 1'b1;
      e.pwrite  = we;
      e.paddr   = {20'h0, addr[11:0]};
      e.pwdata  = wdata;
      e.pstrb   = we ? be : 4'b0000;
      exp_q.push_back(e);
      e.penable = 1'b1;
      for (int i = 0; i < acc; i++) exp_q.push_back(e);
      e = '{default: '0};
      e.ready = 1'b1; e.rdata = res; e.err = rerr;
      exp_q.push_back(e);
      for (int k = 1; k <= 1 + acc; k++) begin
        junk_bus();
        rand_slaves();
        if (k >= 2) begin
          PREADY[s] = (k == 2 + waits);
          if (k == 2 + waits) begin
            PSLVERR[s]         = serr;
            PRDATA[32*s +: 32] = rd;
          end
        end
        @(posedge clk); #1;
      end
    end
    junk_bus();
    idle_cycle();
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got no finish expected finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [19:0] page;
    int          waits;
    reset = 1'b0; transfer = 1'b1; busWe = 1'b1; busAddr = 32'h1000_0000;
    busWData = 32'hFFFF_FFFF; Byte_Enable = 4'hF;
    rand_slaves();
    @(posedge clk); #1;
    exp_reset = 1'b1;
    repeat (2) begin rand_slaves(); @(posedge clk); #1; end
    check("reset_psel", 32'(PSEL), 32'h0);
    check("reset_rdata", busRData, 32'h0);
    reset = 1'b1; transfer = 1'b0;
    @(posedge clk); #1;
    exp_reset = 1'b0;
    repeat (3) idle_cycle();
    check("post_reset_ready", 32'(busReady), 32'h0);

    do_xfer(1'b1, 32'h1000_1004, 32'hA5A5_0001, 4'b0011, 0, 32'h0, 1'b0);
    check("wr_psel", 32'(mon_psel), 32'h2);
    check("wr_paddr", mon_paddr, 32'h004);
    check("wr_pstrb", 32'(mon_pstrb), 32'h3);
    check("wr_latency", 32'(mon_rdy_cyc - start_cyc + 1), 32'd3);
    check("wr_err", 32'(mon_err), 32'h0);

    do_xfer(1'b0, 32'h1000_2010, 32'h0, 4'b1111, 3, 32'h1234_5678, 1'b0);
    check("rd_psel", 32'(mon_psel), 32'h4);
    check("rd_pstrb", 32'(mon_pstrb), 32'h0);
    check("rd_latency", 32'(mon_rdy_cyc - start_cyc + 1), 32'd6);
    check("rd_data", mon_rdata, 32'h1234_5678);

    do_xfer(1'b0, 32'h2000_0000, 32'h0, 4'h0, 0, 32'h0, 1'b0);
    check("unmap_latency", 32'(mon_rdy_cyc - start_cyc + 1), 32'd1);
    check("unmap_rdata", mon_rdata, 32'h0);
    check("unmap_err", 32'(mon_err), 32'h1);

    do_xfer(1'b0, 32'h1000_0040, 32'h0, 4'h0, 1, 32'hCAFE_0000, 1'b1);
    check("slverr_err", 32'(mon_err), 32'h1);
    check("slverr_data", mon_rdata, 32'hCAFE_0000);

    // Reset while ACCESS is waiting on PREADY: no completion pulse may follow.
    begin
      exp_t e;
      transfer = 1'b1; busWe = 1'b0; busAddr = 32'h1000_3000; PREADY = '0;
      mon_rdy_cyc = -1;
      @(posedge clk); #1;
      e = '{default: '0};
      e.psel = 4'b1000; e.paddr = 32'h0; e.pwrite = 1'b0; e.pstrb = 4'b0000;
      exp_q.push_back(e);
      e.penable = 1'b1;
      exp_q.push_back(e);
      transfer = 1'b0; PREADY = '0;
      @(posedge clk); #1;
      reset = 1'b0; PREADY = '0;
      @(posedge clk); #1;
      exp_reset = 1'b1;
      reset = 1'b1; PREADY = '1;
      @(posedge clk); #1;
      exp_reset = 1'b0;
      repeat (4) idle_cycle();
      check("midrst_no_ready", 32'(mon_rdy_cyc), 32'hFFFF_FFFF);
    end

`ifdef APB_TIMEOUT_EN
    do_xfer(1'b0, 32'h1000_1000, 32'h0, 4'h0, 50, 32'h1111_2222, 1'b0);
    check("timeout_latency", 32'(mon_rdy_cyc - start_cyc + 1), 32'd6);
    check("timeout_data", mon_rdata, 32'hDEAD_BEEF);
    check("timeout_err", 32'(mon_err), 32'h1);
`endif

    for (int n = 0; n < 80; n++) begin
      if ($urandom_range(0, 9) < 2) begin
        page = 20'($urandom());
        if (page - BP < 20'(NS)) page = 20'h2000_0;
        if ($urandom_range(0, 1) == 1) page = ($urandom_range(0, 1) == 1) ? BP - 20'd1 : BP + 20'(NS);
      end else begin
        page = BP + 20'($urandom_range(0, NS - 1));
      end
`ifdef APB_TIMEOUT_EN
      waits = $urandom_range(0, 6);
`else
      waits = $urandom_range(0, 5);
`endif
      do_xfer(1'($urandom()), {page, 12'($urandom())}, $urandom(), 4'($urandom()), waits,
              $urandom(), ($urandom_range(0, 3) == 0));
      repeat ($urandom_range(0, 2)) idle_cycle();
    end

    repeat (3) idle_cycle();
    check("queue_drained", 32'(exp_q.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
